bm_buf_alloc: RTL and testbench



---
 rtl/bm_buf_alloc_if.sv | 30 +++
 rtl/bm_buf_alloc.sv | 138 +++++++++++++
 tb/tb_bm_buf_alloc.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bm_buf_alloc_if.sv
// rtl/bm_buf_alloc_if.sv - allocator request, grant, free and link-write bundle
interface bm_buf_alloc_if #(
  parameter int PTR_W = 4
);
  logic             alloc_req;
  logic             alloc_sop;
  logic             alloc_eop;
  logic             alloc_ready;
  logic             alloc_ack;
  logic [PTR_W-1:0] alloc_buf_ptr;
  logic             free_valid;
  logic [PTR_W-1:0] free_buf_ptr;
  logic             enq_buf_valid;
  logic [PTR_W-1:0] enq_buf_ptr_cur;
  logic [PTR_W-1:0] enq_buf_ptr_nxt;

  // Client side: packet writer, free stage and linked list
  modport master (
    output alloc_req, alloc_sop, alloc_eop, free_valid, free_buf_ptr,
    input  alloc_ready, alloc_ack, alloc_buf_ptr,
    input  enq_buf_valid, enq_buf_ptr_cur, enq_buf_ptr_nxt
  );

  // Allocator side
  modport slave (
    input  alloc_req, alloc_sop, alloc_eop, free_valid, free_buf_ptr,
    output alloc_ready, alloc_ack, alloc_buf_ptr,
    output enq_buf_valid, enq_buf_ptr_cur, enq_buf_ptr_nxt
  );
endinterface

// File: rtl/bm_buf_alloc.sv
// rtl/bm_buf_alloc.sv - free-buffer list, pointer grants and packet chaining
module bm_buf_alloc #(
  parameter int PTR_W   = 4,
  parameter int NUM_BUF = 2**PTR_W
) (
  input  logic           clk,
  input  logic           rst,
  bm_buf_alloc_if.slave  bus,
  output logic [PTR_W:0] free_count,
  output logic           init_done,
  output logic           err_overflow,
  output logic           err_proto
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_BUF - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(NUM_BUF);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state;
  logic [PTR_W-1:0] mem [NUM_BUF];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] prev_ptr;
  logic             in_pkt;
  logic             req_sop;
  logic             req_eop;
  logic             ready;
  logic             pop;
  logic             free_acc;
  logic             free_drop;
  logic             mem_we;
  logic [PTR_W-1:0] mem_wdata;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign bus.alloc_ready = ready;

  // Handshake qualification from registered state only; no free->alloc bypass
  always_comb begin
    ready     = init_done & (free_count != '0);
    pop       = bus.alloc_req & ready;
    free_acc  = bus.free_valid & (state == S_RUN) & (free_count != FULL_CNT);
    free_drop = bus.free_valid & ~free_acc;
    mem_we    = ~rst & ((state == S_INIT) | free_acc);
    mem_wdata = (state == S_INIT) ? tail : bus.free_buf_ptr;
  end

  // Free-list RAM: identity fill during init, returned pointers at tail afterwards
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[tail] <= mem_wdata;
    end
  end

  // Init/run FSM, head/tail/count bookkeeping and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_INIT;
      head         <= '0;
      tail         <= '0;
      free_count   <= '0;
      init_done    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (free_drop) begin
        err_overflow <= 1'b1;
      end
      case (state)
        S_INIT: begin
          tail       <= wrap_inc(tail);
          free_count <= free_count + 1'b1;
          if (tail == LAST_IDX) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          if (pop) begin
            head <= wrap_inc(head);
          end
          if (free_acc) begin
            tail <= wrap_inc(tail);
          end
          case ({free_acc, pop})
            2'b10:   free_count <= free_count + 1'b1;
            2'b01:   free_count <= free_count - 1'b1;
            default: free_count <= free_count;
          endcase
        end
      endcase
    end
  end

  // Grant register plus chaining of consecutive buffers into link writes
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alloc_ack       <= 1'b0;
      bus.alloc_buf_ptr   <= '0;
      req_sop             <= 1'b0;
      req_eop             <= 1'b0;
      prev_ptr            <= '0;
      in_pkt              <= 1'b0;
      bus.enq_buf_valid   <= 1'b0;
      bus.enq_buf_ptr_cur <= '0;
      bus.enq_buf_ptr_nxt <= '0;
      err_proto           <= 1'b0;
    end else begin
      bus.alloc_ack     <= pop;
      bus.enq_buf_valid <= 1'b0;
      if (pop) begin
        bus.alloc_buf_ptr <= mem[head];
        req_sop           <= bus.alloc_sop;
        req_eop           <= bus.alloc_eop;
      end
      if (bus.alloc_ack) begin
        prev_ptr <= bus.alloc_buf_ptr;
        in_pkt   <= ~req_eop;
        if (req_sop) begin
          // A new sop while a packet is open closes the old one without a link
          if (in_pkt) begin
            err_proto <= 1'b1;
          end
        end else if (in_pkt) begin
          bus.enq_buf_valid   <= 1'b1;
          bus.enq_buf_ptr_cur <= prev_ptr;
          bus.enq_buf_ptr_nxt <= bus.alloc_buf_ptr;
        end else begin
          // Orphan continuation: flagged and treated as a packet start
          err_proto <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bm_buf_alloc.sv
// tb/tb_bm_buf_alloc.sv - scoreboard bench for the buffer allocator
module tb_bm_buf_alloc;

  localparam int PTR_W   = 4;
  localparam int NUM_BUF = 16;

  logic           clk;
  logic           rst;
  logic [PTR_W:0] free_count;
  logic           init_done;
  logic           err_overflow;
  logic           err_proto;

  bm_buf_alloc_if #(.PTR_W(PTR_W)) bus ();

  bm_buf_alloc #(.PTR_W(PTR_W), .NUM_BUF(NUM_BUF)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .free_count   (free_count),
    .init_done    (init_done),
    .err_overflow (err_overflow),
    .err_proto    (err_proto)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_grant[$];
  int exp_link[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_req    = 1'b0;
    bus.alloc_sop    = 1'b0;
    bus.alloc_eop    = 1'b0;
    bus.free_valid   = 1'b0;
    bus.free_buf_ptr = '0;
  endtask

  task automatic free_one(input int p);
    bus.free_valid   = 1'b1;
    bus.free_buf_ptr = PTR_W'(p);
    step();
    bus.free_valid   = 1'b0;
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (!init_done && cycles < 100) begin
      step();
      cycles++;
    end
  endtask

  // Monitor: compare every grant and link write against the scoreboard queues
  always @(negedge clk) begin
    if (!rst && bus.alloc_ack) begin
      n_checks++;
      if (exp_grant.size() == 0) begin
        n_fail++;
        $display("FAIL grant_unexpected: got ptr %0d expected no grant", bus.alloc_buf_ptr);
      end else begin
        int e;
        e = exp_grant.pop_front();
        if (int'(bus.alloc_buf_ptr) != e) begin
          n_fail++;
          $display("FAIL grant_ptr: got %0d expected %0d", bus.alloc_buf_ptr, e);
        end
      end
    end
    if (!rst && bus.enq_buf_valid) begin
      n_checks++;
      if (exp_link.size() == 0) begin
        n_fail++;
        $display("FAIL link_unexpected: got %0d->%0d expected no link",
                 bus.enq_buf_ptr_cur, bus.enq_buf_ptr_nxt);
      end else begin
        int e;
        e = exp_link.pop_front();
        if (int'(bus.enq_buf_ptr_cur) * 256 + int'(bus.enq_buf_ptr_nxt) != e) begin
          n_fail++;
          $display("FAIL link_ptrs: got %0d->%0d expected %0d->%0d",
                   bus.enq_buf_ptr_cur, bus.enq_buf_ptr_nxt, e / 256, e % 256);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int frees_a[5]  = '{7, 3, 12, 0, 9};
    int frees_b[6]  = '{5, 6, 8, 10, 11, 13};
    int regrant[10] = '{12, 0, 9, 5, 6, 8, 10, 11, 13, 14};

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("reset_free_count", free_count, 0);
    check("reset_init_done", init_done, 0);
    check("reset_alloc_ready", bus.alloc_ready, 0);
    check("reset_alloc_ack", bus.alloc_ack, 0);
    check("reset_enq_valid", bus.enq_buf_valid, 0);
    check("reset_err_overflow", err_overflow, 0);
    check("reset_err_proto", err_proto, 0);

    // Initialisation timing
    rst = 1'b0;
    wait_init(cyc);
    check("init_cycles", cyc, NUM_BUF);
    check("init_free_count", free_count, NUM_BUF);
    check("init_alloc_ready", bus.alloc_ready, 1);
    check("init_no_overflow", err_overflow, 0);

    // Single-buffer packet
    exp_grant.push_back(0);
    bus.alloc_req = 1'b1; bus.alloc_sop = 1'b1; bus.alloc_eop = 1'b1;
    step();
    idle_inputs();
    check("single_ack", bus.alloc_ack, 1);
    check("single_free_count", free_count, NUM_BUF - 1);
    step();
    step();

    // Three-buffer packet, back-to-back
    exp_grant.push_back(1); exp_grant.push_back(2); exp_grant.push_back(3);
    exp_link.push_back(1 * 256 + 2); exp_link.push_back(2 * 256 + 3);
    bus.alloc_req = 1'b1; bus.alloc_sop = 1'b1; bus.alloc_eop = 1'b0;
    step();
    bus.alloc_sop = 1'b0;
    step();
    check("link_not_yet", bus.enq_buf_valid, 0);
    bus.alloc_eop = 1'b1;
    step();
    idle_inputs();
    check("link1_valid", bus.enq_buf_valid, 1);
    step();
    check("link2_valid", bus.enq_buf_valid, 1);
    step();
    check("link_done", bus.enq_buf_valid, 0);
    check("three_free_count", free_count, NUM_BUF - 4);

    // Drain the free list with extra requests past empty
    for (int p = 4; p < NUM_BUF; p++) exp_grant.push_back(p);
    bus.alloc_req = 1'b1; bus.alloc_sop = 1'b1; bus.alloc_eop = 1'b1;
    repeat (14) step();
    idle_inputs();
    check("empty_free_count", free_count, 0);
    check("empty_alloc_ready", bus.alloc_ready, 0);
    step();
    step();

    // Refill across the wrap; ready returns the cycle after the first free
    free_one(frees_a[0]);
    check("refill_ready", bus.alloc_ready, 1);
    check("refill_count", free_count, 1);
    for (int i = 1; i < 5; i++) free_one(frees_a[i]);
    check("refill5_count", free_count, 5);
    exp_grant.push_back(7);
    bus.alloc_req = 1'b1; bus.alloc_sop = 1'b1; bus.alloc_eop = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 6; i++) free_one(frees_b[i]);
    check("ten_free_count", free_count, 10);

    // Simultaneous free and accepted request
    exp_grant.push_back(3);
    bus.alloc_req = 1'b1; bus.alloc_sop = 1'b1; bus.alloc_eop = 1'b1;
    bus.free_valid = 1'b1; bus.free_buf_ptr = PTR_W'(14);
    step();
    idle_inputs();
    check("simul_free_count", free_count, 10);
    for (int i = 0; i < 10; i++) exp_grant.push_back(regrant[i]);
    bus.alloc_req = 1'b1; bus.alloc_sop = 1'b1; bus.alloc_eop = 1'b1;
    repeat (10) step();
    idle_inputs();
    check("drain2_free_count", free_count, 0);
    step();
    step();
    check("grants_drained", exp_grant.size(), 0);

    // Free during init is dropped and flagged
    rst = 1'b1;
    step();
    step();
    check("rst2_free_count", free_count, 0);
    check("rst2_init_done", init_done, 0);
    rst = 1'b0;
    repeat (3) step();
    check("mid_init_count", free_count, 3);
    free_one(2);
    check("init_free_overflow", err_overflow, 1);
    check("init_free_count", free_count, 4);
    wait_init(cyc);
    check("reinit_free_count", free_count, NUM_BUF);
    check("overflow_held", err_overflow, 1);

    // Free while full, then protocol errors
    rst = 1'b1;
    step();
    step();
    check("rst3_overflow_clear", err_overflow, 0);
    rst = 1'b0;
    wait_init(cyc);
    free_one(5);
    check("full_free_overflow", err_overflow, 1);
    check("full_free_count", free_count, NUM_BUF);
    check("proto_clear", err_proto, 0);
    exp_grant.push_back(0);
    bus.alloc_req = 1'b1; bus.alloc_sop = 1'b0; bus.alloc_eop = 1'b1;
    step();
    idle_inputs();
    step();
    check("orphan_proto", err_proto, 1);
    exp_grant.push_back(1); exp_grant.push_back(2);
    bus.alloc_req = 1'b1; bus.alloc_sop = 1'b1; bus.alloc_eop = 1'b0;
    step();
    bus.alloc_eop = 1'b1;
    step();
    idle_inputs();
    repeat (3) step();
    check("proto_held", err_proto, 1);
    check("overflow_held2", err_overflow, 1);
    check("final_free_count", free_count, NUM_BUF - 3);
    check("final_grants_empty", exp_grant.size(), 0);
    check("final_links_empty", exp_link.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
